// File: rtl/otter_lsu_pkg.sv
// Shared types and constants for the OTTER load/store unit.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
package otter_lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    // Addresses at or above this go to MMIO; the LSU itself never decodes them.
    localparam logic [XLEN-1:0] MMIO_BASE = 32'h0001_0000;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        LD_ISSUE,
        LD_CAPT
    } lsu_state_t;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        logic [SIZE_W-1:0] size;
        logic              sign;
        logic [RD_W-1:0]   rd;
    } lsu_req_t;

endpackage

// File: rtl/otter_lsu_align.sv
// Combinational misalignment check for a data access of the given size.
module otter_lsu_align
    import otter_lsu_pkg::*;
(
    input  logic [SIZE_W-1:0] size,
    input  logic [1:0]        addr_lo,
    output logic              misaligned
);

    // Halves may straddle bytes 1..2 but not cross the word; size 3 is never legal.
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = (addr_lo == 2'd3);
            SIZE_WORD: misaligned = (addr_lo != 2'd0);
            default:   misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/otter_lsu.sv
// MEM-stage load/store unit: one request per handshake, sequenced for synchronous BRAM.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses on ERR instead of issuing them.
module otter_lsu
    import otter_lsu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [XLEN-1:0]   REQ_ADDR,
    input  logic [XLEN-1:0]   REQ_DATA,
    input  logic [SIZE_W-1:0] REQ_SIZE,
    input  logic              REQ_SIGN,
    input  logic [RD_W-1:0]   REQ_RD,
    output logic              RSP_VALID,
    output logic [XLEN-1:0]   RSP_DATA,
    output logic [RD_W-1:0]   RSP_RD,
    output logic              STALL,
    output logic              MEM_RDEN2,
    output logic              MEM_WE2,
    output logic [XLEN-1:0]   MEM_ADDR2,
    output logic [XLEN-1:0]   MEM_DIN2,
    output logic [SIZE_W-1:0] MEM_SIZE,
    output logic              MEM_SIGN,
    input  logic [XLEN-1:0]   MEM_DOUT2,
    output logic              ERR
);

    lsu_state_t      state;
    lsu_req_t        req;
    logic [RD_W-1:0] rd_q;
    logic            accept;
    logic            misaligned;
    logic            trap;

    assign req = '{we: REQ_WE, addr: REQ_ADDR, data: REQ_DATA,
                   size: REQ_SIZE, sign: REQ_SIGN, rd: REQ_RD};
    assign accept = REQ_VALID & REQ_READY;

    otter_lsu_align u_align (
        .size       (REQ_SIZE),
        .addr_lo    (REQ_ADDR[1:0]),
        .misaligned (misaligned)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ERR <= 1'b0;
        end else begin
            ERR <= accept & trap;
        end
    end
`else
    logic align_unused;

    assign align_unused = misaligned;
    assign trap         = 1'b0;
    assign ERR          = 1'b0;
`endif

    // Memory-side fields come only from the holding regs so they stay put through LD_CAPT.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            REQ_READY <= 1'b1;
            STALL     <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            RSP_RD    <= '0;
            rd_q      <= '0;
            MEM_RDEN2 <= 1'b0;
            MEM_WE2   <= 1'b0;
            MEM_ADDR2 <= '0;
            MEM_DIN2  <= '0;
            MEM_SIZE  <= '0;
            MEM_SIGN  <= 1'b0;
        end else begin
            RSP_VALID <= 1'b0;
            MEM_RDEN2 <= 1'b0;
            MEM_WE2   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        MEM_ADDR2 <= req.addr;
                        MEM_DIN2  <= req.data;
                        MEM_SIZE  <= req.size;
                        MEM_SIGN  <= req.sign;
                        rd_q      <= req.rd;
                        if (!trap) begin
                            REQ_READY <= 1'b0;
                            STALL     <= 1'b1;
                            if (req.we) begin
                                state   <= STORE;
                                MEM_WE2 <= 1'b1;
                            end else begin
                                state     <= LD_ISSUE;
                                MEM_RDEN2 <= 1'b1;
                            end
                        end
                    end
                end
                STORE: begin
                    state     <= IDLE;
                    REQ_READY <= 1'b1;
                    STALL     <= 1'b0;
                end
                LD_ISSUE: begin
                    state <= LD_CAPT;
                end
                LD_CAPT: begin
                    state     <= IDLE;
                    REQ_READY <= 1'b1;
                    STALL     <= 1'b0;
                    RSP_VALID <= 1'b1;
                    RSP_DATA  <= MEM_DOUT2;
                    RSP_RD    <= rd_q;
                end
                default: begin
                    state     <= IDLE;
                    REQ_READY <= 1'b1;
                    STALL     <= 1'b0;
                end
            endcase
        end
    end

endmodule
